// File: rtl/bus_if_rr_arb.sv
// rtl/bus_if_rr_arb.sv - round-robin arbiter sharing one Bus_if slave port, in-order response routing
// Optional BUS_IF_RR_ARB_PRIO0_EN: master 0 wins every IDLE-state arbitration it requests in.
package Bus;
   typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} Cmd;
   typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, ERR = 2'd3} Resp;
endpackage

module bus_if_rr_arb #(
   parameter int NUM_MASTERS   = 4,
   parameter int NUM_IN_FLIGHT = 4,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  Bus::Cmd                 m_MCmd        [NUM_MASTERS],
   input  logic [ADDR_W-1:0]       m_MAddr       [NUM_MASTERS],
   input  logic [DATA_W-1:0]       m_MData       [NUM_MASTERS],
   input  logic [DATA_W/8-1:0]     m_MByteEn     [NUM_MASTERS],
   input  logic [NUM_MASTERS-1:0]  m_MDataValid,
   input  logic [NUM_MASTERS-1:0]  m_MRespAccept,
   output logic [NUM_MASTERS-1:0]  m_SCmdAccept,
   output logic [NUM_MASTERS-1:0]  m_SDataAccept,
   output Bus::Resp                m_SResp       [NUM_MASTERS],
   output logic [DATA_W-1:0]       m_SData       [NUM_MASTERS],
   output Bus::Cmd                 s_MCmd,
   output logic [ADDR_W-1:0]       s_MAddr,
   output logic [DATA_W-1:0]       s_MData,
   output logic                    s_MDataValid,
   output logic [DATA_W/8-1:0]     s_MByteEn,
   output logic                    s_MRespAccept,
   input  logic                    s_SCmdAccept,
   input  logic                    s_SDataAccept,
   input  Bus::Resp                s_SResp,
   input  logic [DATA_W-1:0]       s_SData,
   output logic                    busy
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam int PW = (NUM_IN_FLIGHT > 1) ? $clog2(NUM_IN_FLIGHT) : 1;
   localparam int CW = $clog2(NUM_IN_FLIGHT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(NUM_IN_FLIGHT);
   localparam logic [PW-1:0] LAST_PTR = PW'(NUM_IN_FLIGHT - 1);
   localparam logic [IW-1:0] LAST_M   = IW'(NUM_MASTERS - 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t                 state, state_nxt;
   logic [IW-1:0]          grant_q, grant_nxt, last_grant, last_grant_nxt;
   logic [IW-1:0]          win, cand, sel, head;
   logic [NUM_MASTERS-1:0] req;
   logic                   found, sel_valid, fwd, push, pop, full, empty;
   logic [IW-1:0]          rq [NUM_IN_FLIGHT];
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          count;
   logic                   unused_sda;

   // Data-phase handshake is folded into the command accept on this port.
   assign unused_sda = s_SDataAccept;

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) req[i] = (m_MCmd[i] != Bus::IDLE);
   end

   always_comb begin
      win   = last_grant;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = IW'((int'(last_grant) + i) % NUM_MASTERS);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
`ifdef BUS_IF_RR_ARB_PRIO0_EN
      if (req[0]) begin
         found = 1'b1;
         win   = '0;
      end
`else
`endif
   end

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign sel_valid = (state == S_LOCKED) || found;
   assign sel       = (state == S_LOCKED) ? grant_q : win;
   assign fwd       = sel_valid && !full && !Reset;
   assign push      = fwd && s_SCmdAccept;
   assign head      = rq[rd_ptr];
   assign pop       = !empty && !Reset && (s_SResp != Bus::NULL) && m_MRespAccept[head];
   assign busy      = !Reset && (!empty || (state == S_LOCKED));

   always_comb begin
      s_MCmd        = Bus::IDLE;
      s_MAddr       = '0;
      s_MData       = '0;
      s_MDataValid  = 1'b0;
      s_MByteEn     = '0;
      m_SCmdAccept  = '0;
      m_SDataAccept = '0;
      if (fwd) begin
         s_MCmd              = m_MCmd[sel];
         s_MAddr             = m_MAddr[sel];
         s_MData             = m_MData[sel];
         s_MDataValid        = m_MDataValid[sel];
         s_MByteEn           = m_MByteEn[sel];
         m_SCmdAccept[sel]   = push;
         m_SDataAccept[sel]  = push;
      end
   end

   always_comb begin
      s_MRespAccept = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_SResp[i] = Bus::NULL;
         m_SData[i] = '0;
      end
      if (!empty && !Reset) begin
         m_SResp[head] = s_SResp;
         m_SData[head] = s_SData;
         s_MRespAccept = m_MRespAccept[head];
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_q;
      last_grant_nxt = last_grant;
      case (state)
         S_IDLE: begin
            if (fwd) begin
               if (s_SCmdAccept) begin
                  last_grant_nxt = win;
               end else begin
                  grant_nxt = win;
                  state_nxt = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (push) begin
               last_grant_nxt = grant_q;
               state_nxt      = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_IDLE;
         grant_q    <= '0;
         last_grant <= LAST_M;
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Routing queue: one master index per outstanding command, popped in issue order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < NUM_IN_FLIGHT; i++) rq[i] <= '0;
      end else begin
         if (push) begin
            rq[wr_ptr] <= sel;
            wr_ptr     <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
